// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: CPU-facing TX/RX byte FIFOs plus a sequencer that is the
// only master of the UART's 4-word register port (config, load, go, rx read).
module uart_fifo_bridge #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter bit          PRIO_RX = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [1:0]  iAddr,
  input  logic [15:0] iData,
  output logic [15:0] oData,
  input  logic        iWrite,
  input  logic        iEnable,
  output logic        oInt,
  output logic [1:0]  oUAddr,
  output logic [15:0] oUData,
  input  logic [15:0] iUData,
  output logic        oUWrite,
  output logic        oUEnable,
  input  logic        iUInt
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFGWR = 3'd1,
    S_POLL  = 3'd2,
    S_LOAD  = 3'd3,
    S_GO    = 3'd4,
    S_RXRD  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Control/status registers
  logic [DW-1:0] cfg, cfg_next;
  logic          cfgpend, rxpend, ovf, uint_prev;

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [LW-1:0] tx_level;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_flush;
  logic [7:0]    tx_head;

  // RX FIFO
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [LW-1:0] rx_level;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_flush, rx_drop;
  logic [7:0]    rx_head;

  // CPU decode
  logic          cpu_rd, cpu_wr, cfg_wr, ctl_wr, uint_rise, busy;
  logic [DW-1:0] status, rd_data;

  // Registered UART-port outputs, computed for the state being entered
  logic [1:0]    u_addr_nxt;
  logic [DW-1:0] u_data_nxt;
  logic          u_write_nxt, u_enable_nxt;

  // Only bit 7 of the UART status word is consulted
  logic          unused_udata;
  assign unused_udata = ^{iUData[15:8], iUData[6:0]};

  assign cpu_rd   = iEnable & ~iWrite;
  assign cpu_wr   = iEnable & iWrite;
  assign cfg_wr   = cpu_wr & (iAddr == 2'd0);
  assign ctl_wr   = cpu_wr & (iAddr == 2'd3);
  assign tx_flush = ctl_wr & iData[1];
  assign rx_flush = ctl_wr & iData[2];
  assign cfg_next = cfg_wr ? {iData[15:8], 1'b0, iData[6:0]} : cfg;

  assign tx_full  = (tx_level == LW'(DEPTH));
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == LW'(DEPTH));
  assign rx_empty = (rx_level == '0);
  assign tx_head  = tx_mem[tx_rp];
  assign rx_head  = rx_mem[rx_rp];

  assign tx_pop   = (state == S_LOAD) & ~tx_empty;
  assign tx_push  = cpu_wr & (iAddr == 2'd1) & (~tx_full | tx_pop);
  assign rx_pop   = cpu_rd & (iAddr == 2'd2) & ~rx_empty;
  assign rx_push  = (state == S_RXRD) & (~rx_full | rx_pop);
  assign rx_drop  = (state == S_RXRD) & ~rx_push;

  assign uint_rise = iUInt & ~uint_prev;
  assign busy      = (state != S_IDLE);
  assign status    = {8'h00, 2'b00, busy, ovf, rx_full, rx_empty, tx_empty, tx_full};

  // TX FIFO storage
  always_ff @(posedge iClk) begin
    if (tx_push) tx_mem[tx_wp] <= iData[7:0];
  end

  // TX FIFO pointers and level; flush wins over a same-cycle pop
  always_ff @(posedge iClk) begin
    if (iRst || tx_flush) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + LW'(1);
        2'b01:   tx_level <= tx_level - LW'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge iClk) begin
    if (rx_push) rx_mem[rx_wp] <= iUData[7:0];
  end

  // RX FIFO pointers and level
  always_ff @(posedge iClk) begin
    if (iRst || rx_flush) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + LW'(1);
        2'b01:   rx_level <= rx_level - LW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // Previous iUInt for edge detection; tracked through reset to avoid a false edge
  always_ff @(posedge iClk) begin
    uint_prev <= iUInt;
  end

  // Config, pending flags and overflow sticky bit
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cfg     <= '0;
      cfgpend <= 1'b0;
      rxpend  <= 1'b0;
      ovf     <= 1'b0;
      oInt    <= 1'b0;
    end else begin
      cfg <= cfg_next;
      if (cfg_wr)                 cfgpend <= 1'b1;
      else if (state == S_CFGWR)  cfgpend <= 1'b0;
      if (state == S_RXRD)        rxpend  <= 1'b0;
      else if (uint_rise)         rxpend  <= 1'b1;
      if ((uint_rise && rxpend) || rx_drop) ovf <= 1'b1;
      else if (ctl_wr && iData[0])          ovf <= 1'b0;
      oInt <= cfg[6] & ~rx_empty;
    end
  end

  // Sequencer state register
  always_ff @(posedge iClk) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Sequencer next state: config first, then receive, then transmit
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cfgpend)                              state_nxt = S_CFGWR;
        else if (rxpend && (PRIO_RX || tx_empty)) state_nxt = S_RXRD;
        else if (!tx_empty)                       state_nxt = S_POLL;
      end
      S_CFGWR: state_nxt = S_IDLE;
      S_POLL: begin
        if (iUData[7] || tx_empty || tx_flush) state_nxt = S_IDLE;
        else                                    state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = S_GO;
      S_GO:    state_nxt = S_IDLE;
      S_RXRD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // UART-port drive for the state being entered; cfg_next lets GO see a late cfg write
  always_comb begin
    u_addr_nxt   = 2'd0;
    u_data_nxt   = '0;
    u_write_nxt  = 1'b0;
    u_enable_nxt = 1'b0;
    case (state_nxt)
      S_CFGWR: begin
        u_data_nxt   = cfg_next;
        u_write_nxt  = 1'b1;
        u_enable_nxt = 1'b1;
      end
      S_POLL: begin
        u_enable_nxt = 1'b1;
      end
      S_LOAD: begin
        u_addr_nxt   = 2'd1;
        u_data_nxt   = {8'h00, tx_head};
        u_write_nxt  = 1'b1;
        u_enable_nxt = 1'b1;
      end
      S_GO: begin
        u_data_nxt   = cfg_next | 16'h0080;
        u_write_nxt  = 1'b1;
        u_enable_nxt = 1'b1;
      end
      S_RXRD: begin
        u_addr_nxt   = 2'd2;
        u_enable_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // UART-port output registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oUAddr   <= 2'd0;
      oUData   <= '0;
      oUWrite  <= 1'b0;
      oUEnable <= 1'b0;
    end else begin
      oUAddr   <= u_addr_nxt;
      oUData   <= u_data_nxt;
      oUWrite  <= u_write_nxt;
      oUEnable <= u_enable_nxt;
    end
  end

  // CPU read mux, combinational
  always_comb begin
    rd_data = '0;
    case (iAddr)
      2'd0: rd_data = status;
      2'd1: rd_data = DW'(tx_level);
      2'd2: rd_data = rx_empty ? '0 : {8'h00, rx_head};
      2'd3: rd_data = DW'(rx_level);
      default: ;
    endcase
    oData = iEnable ? rd_data : '0;
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed/randomized bench for uart_fifo_bridge with a simple UART register model.
module tb_uart_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        write, enable;
  logic        intr;
  logic [1:0]  u_addr;
  logic [15:0] u_wdata;
  logic [15:0] u_rdata;
  logic        u_write, u_enable, u_int;

  logic        uart_busy;
  logic [7:0]  uart_rx;
  logic [6:0]  uart_cfg = 7'h00;

  int total = 0;
  int bad   = 0;
  int poll_count = 0;
  logic [17:0] log_q [$];
  logic [17:0] exp_q [$];
  logic [7:0]  rx_model [$];
  logic [15:0] cfg_model;

  always #5 clk = ~clk;

  uart_fifo_bridge dut (
    .iClk(clk), .iRst(rst), .iAddr(addr), .iData(wdata), .oData(rdata),
    .iWrite(write), .iEnable(enable), .oInt(intr),
    .oUAddr(u_addr), .oUData(u_wdata), .iUData(u_rdata),
    .oUWrite(u_write), .oUEnable(u_enable), .iUInt(u_int)
  );

  // UART register-port model: addr0 status (bit7 = sending), addr2 rx byte
  always_comb begin
    u_rdata = 16'h0000;
    if (u_enable && !u_write) begin
      case (u_addr)
        2'd0: u_rdata = {8'h00, uart_busy, uart_cfg};
        2'd2: u_rdata = {8'h00, uart_rx};
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (u_enable && u_write && u_addr == 2'd0) uart_cfg <= u_wdata[6:0];
  end

  // Record every UART-port write and count status polls
  always @(negedge clk) begin
    if (u_enable && u_write) log_q.push_back({u_addr, u_wdata});
    if (u_enable && !u_write && u_addr == 2'd0) poll_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; write = 1'b1; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0; write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; write = 1'b0; enable = 1'b1;
    #1 d = rdata;
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  // Reference: a config write shows up as one addr0 write with bit7 cleared
  task automatic set_cfg(input logic [15:0] d);
    cfg_model = d & 16'hFF7F;
    cpu_wr(2'd0, d);
    exp_q.push_back({2'd0, cfg_model});
  endtask

  // Reference: each transmitted byte is a load of addr1 then a go write of cfg|0x80
  task automatic exp_tx(input logic [7:0] b);
    exp_q.push_back({2'd1, 8'h00, b});
    exp_q.push_back({2'd0, cfg_model | 16'h0080});
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_log(input int base, input string tag);
    foreach (exp_q[i]) begin
      if (base + i < log_q.size()) check(tag, 32'(log_q[base + i]), 32'(exp_q[i]));
      else check(tag, 32'h0003_FFFF, 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    uart_rx = b;
    @(negedge clk); u_int = 1'b1;
    @(negedge clk); u_int = 1'b0;
    tick(5);
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  b;
    int base, p0, k;

    rst = 1'b1; addr = 2'd0; wdata = 16'h0; write = 1'b0; enable = 1'b0;
    u_int = 1'b0; uart_busy = 1'b0; uart_rx = 8'h00; cfg_model = 16'h0;
    tick(3);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_uport", 32'({u_addr, u_wdata, u_write, u_enable, intr}), 32'd0);
    check("odata_deselected", 32'(rdata), 32'd0);
    cpu_rd(2'd0, d); check("rst_status", 32'(d), 32'h0006);
    cpu_rd(2'd1, d); check("rst_txlevel", 32'(d), 32'd0);
    cpu_rd(2'd3, d); check("rst_rxlevel", 32'(d), 32'd0);
    cpu_rd(2'd2, d); check("rx_empty_read", 32'(d), 32'd0);

    // Config then one byte: CFGWR, POLL, LOAD, GO
    base = log_q.size(); p0 = poll_count;
    set_cfg(16'h0063);
    cpu_wr(2'd1, 16'h0041); exp_tx(8'h41);
    wait_log(base + 3, 40, "first_byte_timeout");
    check_log(base, "first_byte_seq");
    check("first_byte_polled", 32'(poll_count > p0), 32'd1);

    // UART busy: polls repeat, no load until bit7 clears
    uart_busy = 1'b1;
    base = log_q.size(); p0 = poll_count;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      cpu_wr(2'd1, {8'h00, b}); exp_tx(b);
    end
    cpu_rd(2'd1, d); check("busy_txlevel3", 32'(d), 32'd3);
    tick(40);
    check("busy_no_load", 32'(log_q.size()), 32'(base));
    check("busy_polls", 32'(poll_count - p0 >= 2), 32'd1);
    cpu_rd(2'd1, d); check("busy_txlevel_held", 32'(d), 32'd3);
    uart_busy = 1'b0;
    wait_log(base + 6, 60, "busy_drain_timeout");
    check_log(base, "busy_order");
    cpu_rd(2'd1, d); check("busy_txlevel0", 32'(d), 32'd0);

    // 17 pushes while busy: 16 kept, last dropped, no overflow flag
    uart_busy = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      cpu_wr(2'd1, {8'h00, b});
      if (i < 16) exp_tx(b);
    end
    cpu_rd(2'd1, d); check("full_txlevel", 32'(d), 32'd16);
    cpu_rd(2'd0, d); check("full_status", 32'(d & 16'hFFDF), 32'h0005);
    uart_busy = 1'b0;
    wait_log(base + 32, 200, "full_drain_timeout");
    check_log(base, "full_order");
    tick(4);
    check("full_no_17th", 32'(log_q.size()), 32'(base + 32));

    // TX flush discards queued bytes
    uart_busy = 1'b1;
    cpu_wr(2'd1, 16'h0011);
    cpu_wr(2'd1, 16'h0022);
    cpu_wr(2'd3, 16'h0002);
    cpu_rd(2'd1, d); check("flush_txlevel", 32'(d), 32'd0);
    uart_busy = 1'b0;
    base = log_q.size();
    tick(10);
    check("flush_no_send", 32'(log_q.size()), 32'(base));

    // Interrupt enable; bit7 of cfg cannot be set by the CPU
    base = log_q.size();
    set_cfg(16'h00C0);
    wait_log(base + 1, 20, "cfg_timeout");
    check_log(base, "cfg_bit7_forced");

    // Single receive
    pulse_rx(8'h5A);
    cpu_rd(2'd3, d); check("rx1_level", 32'(d), 32'd1);
    check("rx1_int", 32'(intr), 32'd1);
    cpu_rd(2'd2, d); check("rx1_data", 32'(d), 32'h005A);
    tick(2);
    check("rx1_int_clear", 32'(intr), 32'd0);

    // Fill RX with random bytes, then one extra edge overflows
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      rx_model.push_back(b);
      pulse_rx(b);
    end
    cpu_rd(2'd3, d); check("rxfull_level", 32'(d), 32'd16);
    cpu_rd(2'd0, d); check("rxfull_status", 32'(d), 32'h000A);
    pulse_rx(8'(~rx_model[0]));
    cpu_rd(2'd0, d); check("rxovf_status", 32'(d), 32'h001A);
    cpu_rd(2'd3, d); check("rxovf_level", 32'(d), 32'd16);
    k = 0;
    while (rx_model.size() > 0) begin
      b = rx_model.pop_front();
      cpu_rd(2'd2, d); check($sformatf("rx_data%0d", k), 32'(d), 32'(b));
      k++;
    end
    cpu_rd(2'd2, d); check("rx_drained_read", 32'(d), 32'd0);
    cpu_rd(2'd0, d); check("rx_drained_status", 32'(d), 32'h0016);
    cpu_wr(2'd3, 16'h0001);
    cpu_rd(2'd0, d); check("ovf_cleared", 32'(d), 32'h0006);
    tick(2);
    check("rx_int_low", 32'(intr), 32'd0);

    // Reset in the middle of LOAD
    cpu_wr(2'd1, {8'h00, 8'($urandom)});
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (u_enable && u_write && u_addr == 2'd1) break;
      k++;
    end
    check("load_seen", 32'(k < 20), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_load_uport", 32'({u_write, u_enable}), 32'd0);
    @(negedge clk); rst = 1'b0;
    cpu_rd(2'd0, d); check("rst_load_status", 32'(d), 32'h0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
